// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: N-way request arbiter with run-time choice of round-robin
// or fixed (LSB-first) priority, plus a grant lock for multi-cycle transfers.
// The grant is combinational from the current requests and state (0-cycle
// latency); pointer, lock state and locked index update on the rising edge.
module rr_lock_arbiter #(
  parameter int N    = 32,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_i,
  input  logic            rr_en_i,
  input  logic            hold_i,
  output logic [N-1:0]    gnt_o,
  output logic            gnt_valid_o,
  output logic [IDXW-1:0] gnt_idx_o
);

  localparam logic [0:0]      ST_ARB    = 1'b0;
  localparam logic [0:0]      ST_LOCKED = 1'b1;
  localparam logic [IDXW-1:0] IDX_ZERO  = {IDXW{1'b0}};
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(N - 1);
  localparam logic [N-1:0]    VEC_ZERO  = {N{1'b0}};
  localparam logic [N-1:0]    VEC_ONE   = {{(N-1){1'b0}}, 1'b1};

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic logic [IDXW-1:0] lowest_idx(input logic [N-1:0] v);
    logic [IDXW-1:0] idx;
    idx = IDX_ZERO;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDXW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [0:0]      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] lock_idx_q, lock_idx_d;

  logic [N-1:0]    mask_s;
  logic [N-1:0]    masked_s;
  logic [IDXW-1:0] arb_idx_s;
  logic            arb_any_s;
  logic            lock_hit_s;
  logic [IDXW-1:0] gnt_idx_s;
  logic            gnt_valid_s;
  logic [N-1:0]    gnt_s;

  // Round-robin window: requesters at or above the pointer go first.
  always_comb begin
    mask_s = VEC_ZERO;
    for (int i = 0; i < N; i++) begin
      mask_s[i] = (IDXW'(i) >= ptr_q);
    end
  end

  // Plain arbitration: fixed LSB-first, or round-robin with wrap-around.
  always_comb begin
    masked_s  = req_i & mask_s;
    arb_any_s = |req_i;
    if (!rr_en_i) begin
      arb_idx_s = lowest_idx(req_i);
    end else if (|masked_s) begin
      arb_idx_s = lowest_idx(masked_s);
    end else begin
      arb_idx_s = lowest_idx(req_i);
    end
  end

  // A lock survives only while its owner keeps requesting with hold_i high;
  // otherwise the same cycle falls back to plain arbitration.
  always_comb begin
    lock_hit_s = 1'b0;
    case (state_q)
      ST_LOCKED: lock_hit_s = hold_i & req_i[lock_idx_q];
      ST_ARB:    lock_hit_s = 1'b0;
      default:   lock_hit_s = 1'b0;
    endcase
  end

  // Final grant selection, index and one-hot vector.
  always_comb begin
    gnt_valid_s = lock_hit_s | arb_any_s;
    if (lock_hit_s) begin
      gnt_idx_s = lock_idx_q;
    end else if (arb_any_s) begin
      gnt_idx_s = arb_idx_s;
    end else begin
      gnt_idx_s = IDX_ZERO;
    end
    if (gnt_valid_s) begin
      gnt_s = VEC_ONE << gnt_idx_s;
    end else begin
      gnt_s = VEC_ZERO;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the clock.
  always_comb begin
    if (reset) begin
      gnt_o       = gnt_s;
      gnt_valid_o = gnt_valid_s;
      gnt_idx_o   = gnt_idx_s;
    end else begin
      gnt_o       = VEC_ZERO;
      gnt_valid_o = 1'b0;
      gnt_idx_o   = IDX_ZERO;
    end
  end

  // Next-state: lock on any grant issued with hold_i, advance the pointer
  // past every round-robin grant (a held lock rewrites the same value).
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    if (gnt_valid_s && hold_i) begin
      state_d    = ST_LOCKED;
      lock_idx_d = gnt_idx_s;
    end else begin
      state_d    = ST_ARB;
      lock_idx_d = lock_idx_q;
    end
    if (gnt_valid_s && rr_en_i) begin
      if (gnt_idx_s == IDX_LAST) begin
        ptr_d = IDX_ZERO;
      end else begin
        ptr_d = gnt_idx_s + IDXW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_ARB;
      ptr_q      <= IDX_ZERO;
      lock_idx_q <= IDX_ZERO;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Testbench for rr_lock_arbiter (N=4): directed scenarios followed by random
// traffic, all checked against a scan-based reference model.
module tb_rr_lock_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic         rr_en;
  logic         hold;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_idx;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_ptr    = 0;
  bit m_locked = 1'b0;
  int m_lidx   = 0;

  rr_lock_arbiter #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .rr_en_i     (rr_en),
    .hold_i      (hold),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scan requesters starting at the priority origin, wrapping modulo N.
  function automatic int model_arb(input logic [N-1:0] r, input bit rr);
    int start;
    int idx;
    start = rr ? m_ptr : 0;
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int model_grant(input logic [N-1:0] r, input bit rr, input bit h);
    if (m_locked && h && r[m_lidx]) return m_lidx;
    return model_arb(r, rr);
  endfunction

  task automatic model_reset();
    m_ptr    = 0;
    m_locked = 1'b0;
    m_lidx   = 0;
  endtask

  // Apply inputs after the falling edge, check, then advance the model to
  // what the next rising edge will commit. exp_idx: -2 = model only,
  // -1 = no grant expected, >=0 = expected index.
  task automatic step(input logic [N-1:0] r, input logic rr, input logic h, input int exp_idx);
    int           g;
    int           obs_i;
    logic [N-1:0] one;
    logic [N-1:0] exp_gnt;
    @(negedge clk);
    req   = r;
    rr_en = rr;
    hold  = h;
    #1;
    one = 4'b0001;
    g   = model_grant(r, rr, h);
    exp_gnt = (g >= 0) ? (one << g) : 4'b0000;

    tests++;
    assert (gnt === exp_gnt)
      else begin fails++; $error("FAIL gnt req=%b obs=%b exp=%b", r, gnt, exp_gnt); end
    tests++;
    assert (gnt_valid === (g >= 0))
      else begin fails++; $error("FAIL valid obs=%b exp=%b", gnt_valid, (g >= 0)); end
    tests++;
    assert (int'(gnt_idx) === ((g >= 0) ? g : 0))
      else begin fails++; $error("FAIL idx obs=%0d exp=%0d", gnt_idx, (g >= 0) ? g : 0); end
    tests++;
    assert (($countones(gnt) <= 1) && ((gnt & ~r) == 4'b0000))
      else begin fails++; $error("FAIL invariant gnt=%b req=%b", gnt, r); end
    if (exp_idx != -2) begin
      obs_i = gnt_valid ? int'(gnt_idx) : -1;
      tests++;
      assert (obs_i == exp_idx)
        else begin fails++; $error("FAIL directed obs=%0d exp=%0d", obs_i, exp_idx); end
    end

    if (g >= 0 && h) begin
      m_locked = 1'b1;
      m_lidx   = g;
    end else begin
      m_locked = 1'b0;
    end
    if (g >= 0 && rr) m_ptr = (g + 1) % N;
  endtask

  task automatic check_quiet(input string tag);
    tests++;
    assert (gnt === 4'b0000 && gnt_valid === 1'b0 && gnt_idx === 2'b00)
      else begin fails++; $error("FAIL %s obs gnt=%b v=%b idx=%0d exp 0", tag, gnt, gnt_valid, gnt_idx); end
  endtask

  initial begin
    reset = 1'b0;
    req   = 4'b1111;
    rr_en = 1'b1;
    hold  = 1'b1;
    #2;
    check_quiet("reset_state");
    @(negedge clk);
    req   = 4'b0000;
    hold  = 1'b0;
    reset = 1'b1;
    model_reset();

    // Fixed mode, 1010 held three cycles
    step(4'b1010, 1'b0, 1'b0, 1);
    step(4'b1010, 1'b0, 1'b0, 1);
    step(4'b1010, 1'b0, 1'b0, 1);
    // RR from ptr 0: 0,1,2,3,0
    step(4'b1111, 1'b1, 1'b0, 0);
    step(4'b1111, 1'b1, 1'b0, 1);
    step(4'b1111, 1'b1, 1'b0, 2);
    step(4'b1111, 1'b1, 1'b0, 3);
    step(4'b1111, 1'b1, 1'b0, 0);
    // Reach ptr 3, then wrap
    step(4'b0100, 1'b1, 1'b0, 2);
    step(4'b0101, 1'b1, 1'b0, 0);
    step(4'b0101, 1'b1, 1'b0, 2);
    // Lock on idx 1 for three cycles, then release
    step(4'b0110, 1'b1, 1'b1, 1);
    step(4'b0110, 1'b1, 1'b1, 1);
    step(4'b0110, 1'b1, 1'b1, 1);
    step(4'b0110, 1'b1, 1'b0, 2);
    // Lock survives a mode change
    step(4'b0101, 1'b1, 1'b1, 0);
    step(4'b0101, 1'b0, 1'b1, 0);
    step(4'b0111, 1'b1, 1'b1, 0);
    step(4'b0100, 1'b1, 1'b0, 2);
    // Lock on 2, owner drops: same-cycle grant 3, relock on 3
    step(4'b0100, 1'b1, 1'b1, 2);
    step(4'b1011, 1'b1, 1'b1, 3);
    step(4'b1011, 1'b1, 1'b1, 3);
    // Hold with no requests: no grant, lock dropped
    step(4'b0000, 1'b1, 1'b1, -1);
    step(4'b1001, 1'b1, 1'b1, 0);
    step(4'b1001, 1'b1, 1'b1, 0);

    // Async reset mid-lock, between edges
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_quiet("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(4'b1000, 1'b1, 1'b0, 3);
    step(4'b1001, 1'b1, 1'b0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), -2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
